// File: rtl/product_accumulator_pkg.sv
// Shared constants and helpers for the product accumulator: lane width,
// tree depth and the saturating add used by the window accumulator.
package product_accumulator_pkg;

    function automatic int lane_width(input int num_width);
        return 2 * num_width;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Returns {saturated, value}; value is clamped to 2^width-1 (width <= 63).
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return {1'b1, lim[63:0]};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Beat input and window result bundle of the product accumulator.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int array_size = 16,
    parameter int num_width  = 8,
    parameter int acc_width  = 32,
    parameter int beat_width = 8
);
    // No backpressure: a beat is taken whenever in_valid is high on an enabled
    // edge; out_valid is a one-cycle pulse and the result fields hold between pulses.
    logic                                         in_valid;
    logic                                         in_last;
    logic [lane_width(num_width)*array_size-1:0]  in_data;
    logic                                         out_valid;
    logic [acc_width-1:0]                         out_sum;
    logic [beat_width-1:0]                        out_beats;
    logic                                         out_ovf;

    modport master (
        output in_valid, in_last, in_data,
        input  out_valid, out_sum, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_last, in_data,
        output out_valid, out_sum, out_beats, out_ovf
    );

endinterface

// File: rtl/product_accumulator_adder_tree_stage.sv
// One registered level of the adder tree: lanes_in/2 pairwise sums, one bit
// wider than the inputs, plus the beat's valid/last flags.
module adder_tree_stage
    import product_accumulator_pkg::*;
#(
    parameter int lanes_in = 2,
    parameter int width_in = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      enable,
    input  logic                                      in_valid,
    input  logic                                      in_last,
    input  logic [lanes_in*width_in-1:0]              in_data,
    output logic                                      out_valid,
    output logic                                      out_last,
    output logic [(lanes_in/2)*(width_in+1)-1:0]      out_data
);
    localparam int LANES_OUT = lanes_in / 2;
    localparam int WIDTH_OUT = width_in + 1;

    logic [LANES_OUT*WIDTH_OUT-1:0] sum_d, sum_q;
    logic                           valid_d, valid_q;
    logic                           last_d, last_q;

    always_comb begin
        sum_d   = sum_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (enable) begin
            valid_d = in_valid;
            last_d  = in_last;
            for (int i = 0; i < LANES_OUT; i++) begin
                sum_d[i*WIDTH_OUT +: WIDTH_OUT] =
                    WIDTH_OUT'(in_data[2*i*width_in +: width_in]) +
                    WIDTH_OUT'(in_data[(2*i+1)*width_in +: width_in]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = sum_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

endmodule

// File: rtl/product_accumulator.sv
// Reduces beats of packed products to one saturated sum per window: input
// register, log2(array_size) adder-tree stages, then a sticky-saturating accumulator.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int array_size = 16,
    parameter int num_width  = 8,
    parameter int acc_width  = 32,
    parameter int beat_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    product_accumulator_if.slave  bus
);
    localparam int LW = lane_width(num_width);
    localparam int D  = clog2(array_size);
    localparam int TW = LW + D;

    logic [LW*array_size-1:0] s0_data_d, s0_data_q;
    logic                     s0_valid_d, s0_valid_q;
    logic                     s0_last_d, s0_last_q;

    always_comb begin
        s0_data_d  = s0_data_q;
        s0_valid_d = s0_valid_q;
        s0_last_d  = s0_last_q;
        if (enable) begin
            s0_data_d  = bus.in_data;
            s0_valid_d = bus.in_valid;
            s0_last_d  = bus.in_valid & bus.in_last;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_data_q  <= '0;
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
        end else begin
            s0_data_q  <= s0_data_d;
            s0_valid_q <= s0_valid_d;
            s0_last_q  <= s0_last_d;
        end
    end

    for (genvar s = 1; s <= D; s++) begin : g_stage
        localparam int LANES_IN = array_size >> (s - 1);
        localparam int W_IN     = LW + s - 1;

        logic [LANES_IN*W_IN-1:0]         din;
        logic                             vin, lin;
        logic [(LANES_IN/2)*(W_IN+1)-1:0] dout;
        logic                             vout, lout;

        if (s == 1) begin : g_src
            assign din = s0_data_q;
            assign vin = s0_valid_q;
            assign lin = s0_last_q;
        end else begin : g_src
            assign din = g_stage[s-1].dout;
            assign vin = g_stage[s-1].vout;
            assign lin = g_stage[s-1].lout;
        end

        adder_tree_stage #(
            .lanes_in (LANES_IN),
            .width_in (W_IN)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .in_valid  (vin),
            .in_last   (lin),
            .in_data   (din),
            .out_valid (vout),
            .out_last  (lout),
            .out_data  (dout)
        );
    end

    logic [TW-1:0] tree_sum;
    logic          tree_valid, tree_last;

    assign tree_sum   = g_stage[D].dout;
    assign tree_valid = g_stage[D].vout;
    assign tree_last  = g_stage[D].lout;

    logic [acc_width-1:0]  acc_d, acc_q;
    logic [beat_width-1:0] beats_d, beats_q;
    logic                  ovf_d, ovf_q;
    logic [acc_width-1:0]  out_sum_d, out_sum_q;
    logic [beat_width-1:0] out_beats_d, out_beats_q;
    logic                  out_ovf_d, out_ovf_q;
    logic                  out_valid_d, out_valid_q;
    logic [64:0]           add_r;
    logic                  add_sat;
    logic [beat_width-1:0] beat_inc;

    always_comb begin
        add_r    = sat_add(64'(acc_q), 64'(tree_sum), acc_width);
        // Clamped value never reaches above acc_width bits; folding them in is harmless.
        add_sat  = add_r[64] | (|add_r[63:acc_width]);
        beat_inc = (beats_q == '1) ? beats_q : beats_q + 1'b1;

        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = 1'b0;

        if (enable && tree_valid) begin
            if (tree_last) begin
                out_sum_d   = add_r[acc_width-1:0];
                out_beats_d = beat_inc;
                out_ovf_d   = ovf_q | add_sat;
                out_valid_d = 1'b1;
                acc_d       = '0;
                beats_d     = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d       = add_r[acc_width-1:0];
                beats_d     = beat_inc;
                ovf_d       = ovf_q | add_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: a default instance and an acc_width=20 instance share the
// same beat stream; every pulse is matched against an expected queue per instance.
module tb_product_accumulator;

    localparam int N    = 16;
    localparam int NW   = 8;
    localparam int LW   = 2 * NW;
    localparam int DW   = N * LW;
    localparam int AW_A = 32;
    localparam int AW_B = 20;
    localparam int BW   = 8;
    localparam int LAT  = 5;
    localparam logic [63:0] MAX_B = (64'd1 << AW_B) - 64'd1;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    product_accumulator_if #(.array_size(N), .num_width(NW), .acc_width(AW_A), .beat_width(BW)) bus_a ();
    product_accumulator_if #(.array_size(N), .num_width(NW), .acc_width(AW_B), .beat_width(BW)) bus_b ();

    product_accumulator #(.array_size(N), .num_width(NW), .acc_width(AW_A), .beat_width(BW)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus_a)
    );

    product_accumulator #(.array_size(N), .num_width(NW), .acc_width(AW_B), .beat_width(BW)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus_b)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] sum;
        logic [7:0]  beats;
        logic        ovf;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic v, input logic last, input logic [DW-1:0] data);
        bus_a.in_valid = v;
        bus_a.in_last  = last;
        bus_a.in_data  = data;
        bus_b.in_valid = v;
        bus_b.in_last  = last;
        bus_b.in_data  = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] data, input logic last);
        set_in(1'b1, last, data);
        tick();
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, '0);
        repeat (n) tick();
    endtask

    function automatic logic [DW-1:0] fill(input logic [15:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*LW +: LW] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] lane_only(input int lane, input logic [15:0] v);
        logic [DW-1:0] d;
        d = '0;
        d[lane*LW +: LW] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] ramp();
        logic [DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*LW +: LW] = 16'(i + 1);
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Called right after the last beat's sampling edge; true_sum is the unclamped window sum.
    task automatic expect_win(input logic [63:0] true_sum, input logic [7:0] beats, input int delay = 0);
        exp_t e;
        e.cyc   = 32'(cyc + LAT + delay);
        e.beats = beats;
        e.sum   = true_sum;
        e.ovf   = 1'b0;
        exp_a_q.push_back(e);
        if (true_sum > MAX_B) begin
            e.sum = MAX_B;
            e.ovf = 1'b1;
        end
        exp_b_q.push_back(e);
    endtask

    task automatic wait_drain();
        set_in(1'b0, 1'b0, '0);
        for (int i = 0; i < 40 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) tick();
        check("drain_a", 64'(exp_a_q.size()), 64'd0);
        check("drain_b", 64'(exp_b_q.size()), 64'd0);
        exp_a_q.delete();
        exp_b_q.delete();
        idle(3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_a_valid"}, 64'(bus_a.out_valid), 64'd0);
        check({tag, "_a_sum"},   64'(bus_a.out_sum),   64'd0);
        check({tag, "_a_beats"}, 64'(bus_a.out_beats), 64'd0);
        check({tag, "_a_ovf"},   64'(bus_a.out_ovf),   64'd0);
        check({tag, "_b_sum"},   64'(bus_b.out_sum),   64'd0);
        check({tag, "_b_ovf"},   64'(bus_b.out_ovf),   64'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (bus_a.out_valid !== 1'b0) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_pulse", 64'(bus_a.out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_a_q.pop_front();
                check("a_pulse_cycle", 64'(cyc),             64'(e.cyc));
                check("a_sum",         64'(bus_a.out_sum),   e.sum);
                check("a_beats",       64'(bus_a.out_beats), 64'(e.beats));
                check("a_ovf",         64'(bus_a.out_ovf),   64'(e.ovf));
            end
        end
        if (bus_b.out_valid !== 1'b0) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_pulse", 64'(bus_b.out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_b_q.pop_front();
                check("b_pulse_cycle", 64'(cyc),             64'(e.cyc));
                check("b_sum",         64'(bus_b.out_sum),   e.sum);
                check("b_beats",       64'(bus_b.out_beats), 64'(e.beats));
                check("b_ovf",         64'(bus_b.out_ovf),   64'(e.ovf));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        set_in(1'b0, 1'b0, '0);
        repeat (6) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_data());
            tick();
        end
        check_outputs_zero("in_reset");
        set_in(1'b0, 1'b0, '0);
        reset = 1'b1;
        idle(10);
        check_outputs_zero("after_release");

        // one-beat window, all lanes 1
        send(fill(16'h0001), 1'b1);
        expect_win(64'd16, 8'd1);
        wait_drain();

        // three beats of 0xFE01
        send(fill(16'hFE01), 1'b0);
        send(fill(16'hFE01), 1'b0);
        send(fill(16'hFE01), 1'b1);
        expect_win(64'd3121200, 8'd3);
        wait_drain();

        // back-to-back one-beat windows
        send(fill(16'h0002), 1'b1);
        expect_win(64'd32, 8'd1);
        send(fill(16'h0003), 1'b1);
        expect_win(64'd48, 8'd1);
        wait_drain();

        // distinct lane values, then only the top lane
        send(ramp(), 1'b1);
        expect_win(64'd136, 8'd1);
        send(lane_only(N - 1, 16'hFFFF), 1'b1);
        expect_win(64'd65535, 8'd1);
        wait_drain();

        // 20-bit saturation edge: exactly all-ones, then one past
        send(fill(16'hFFFF), 1'b0);
        send(lane_only(0, 16'd15), 1'b1);
        expect_win(64'd1048575, 8'd2);
        send(fill(16'hFFFF), 1'b0);
        send(lane_only(0, 16'd16), 1'b1);
        expect_win(64'd1048576, 8'd2);
        wait_drain();

        // two beats of 0xFE01 saturate at 20 bits; the next window starts clean
        send(fill(16'hFE01), 1'b0);
        send(fill(16'hFE01), 1'b1);
        expect_win(64'd2080800, 8'd2);
        send(fill(16'h0001), 1'b1);
        expect_win(64'd16, 8'd1);
        wait_drain();

        // stall after the last beat: pulse moves by exactly 3 cycles, stalled beats dropped
        send(fill(16'h0004), 1'b1);
        expect_win(64'd64, 8'd1, 3);
        enable = 1'b0;
        set_in(1'b1, 1'b1, fill(16'h0007));
        repeat (3) tick();
        enable = 1'b1;
        wait_drain();
        check("hold_sum_a", 64'(bus_a.out_sum), 64'd64);
        check("hold_beats_a", 64'(bus_a.out_beats), 64'd1);

        // stall between beats of one window
        send(fill(16'h0002), 1'b0);
        enable = 1'b0;
        set_in(1'b1, 1'b0, fill(16'h0100));
        repeat (2) tick();
        enable = 1'b1;
        send(fill(16'h0003), 1'b1);
        expect_win(64'd80, 8'd2);
        wait_drain();

        // reset mid-window discards partial sums already in flight
        send(fill(16'h0005), 1'b0);
        send(fill(16'h0005), 1'b0);
        idle(2);
        reset = 1'b0;
        tick();
        check_outputs_zero("mid_reset");
        reset = 1'b1;
        send(fill(16'h0001), 1'b1);
        expect_win(64'd16, 8'd1);
        wait_drain();

        // beat counter saturates at 255
        for (int i = 0; i < 299; i++) send(fill(16'h0000), 1'b0);
        send(fill(16'h0000), 1'b1);
        expect_win(64'd0, 8'd255);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
